// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a hardwired zero
// register and a per-register pending-write scoreboard for RAW hazard checks.
// Optional feature: define REGFILE_BYPASS_EN for write-first reads (same-cycle
// writeback data forwarded to matching read ports, busy masked). Undefined
// gives read-first behaviour.
module regfile_mp #(
  parameter  int NUM_REG   = 32,
  parameter  int REG_WIDTH = 64,
  parameter  int NUM_READ  = 2,
  parameter  int ZERO_REG  = NUM_REG - 1,
  localparam int AW        = $clog2(NUM_REG),
  localparam int CW        = $clog2(NUM_REG + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_READ*AW-1:0]        ReadRegister,
  output logic [NUM_READ*REG_WIDTH-1:0] ReadData,
  output logic [NUM_READ-1:0]           ReadBusy,
  input  logic [AW-1:0]                 WriteRegister,
  input  logic [REG_WIDTH-1:0]          WriteData,
  input  logic                          RegWrite,
  input  logic [AW-1:0]                 IssueRegister,
  input  logic                          IssueValid,
  output logic [CW-1:0]                 PendingCount
);

  localparam logic [AW-1:0] ZR      = AW'(ZERO_REG);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_REG - 1);

  // The ZERO_REG slot exists in the array but is never written and never read
  // out, so it is optimised away; keeping it avoids index remapping.
  logic [NUM_REG-1:0][REG_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REG-1:0]                pend_q, pend_d;
  logic [CW-1:0]                     cnt_q, cnt_d;

  logic          wr_en;
  logic          iss_en;
  logic          cnt_inc;
  logic          cnt_dec;
  logic [AW-1:0] ridx;

  // Qualify writeback and issue: anything targeting the zero register is dropped.
  always_comb begin
    wr_en  = RegWrite && (WriteRegister != ZR);
    iss_en = IssueValid && (IssueRegister != ZR);
  end

  // Next register contents: single writeback port.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteRegister] = WriteData;
    end
  end

  // Next scoreboard: issue sets, writeback clears, set wins on collision.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 0; r < NUM_REG; r++) begin
      if (iss_en && (IssueRegister == AW'(r))) begin
        pend_d[r] = 1'b1;
      end else if (wr_en && (WriteRegister == AW'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
    pend_d[ZR] = 1'b0;
  end

  // Next pending count: derived from the old bits so it tracks popcount(pend_q)
  // without an adder tree; a write that loses to a same-register issue is no clear.
  always_comb begin
    cnt_inc = iss_en && !pend_q[IssueRegister];
    cnt_dec = wr_en && pend_q[WriteRegister] &&
              !(iss_en && (IssueRegister == WriteRegister));
    cnt_d   = cnt_q;
    if (cnt_inc && !cnt_dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (cnt_dec && !cnt_inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // State registers with synchronous reset taking priority over all updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports with zero-register forcing and optional bypass.
  always_comb begin
    ReadData = '0;
    ReadBusy = '0;
    ridx     = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      ridx = ReadRegister[i*AW +: AW];
      if (ridx != ZR) begin
        ReadData[i*REG_WIDTH +: REG_WIDTH] = regs_q[ridx];
        ReadBusy[i]                        = pend_q[ridx];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (ridx == WriteRegister)) begin
          ReadData[i*REG_WIDTH +: REG_WIDTH] = WriteData;
          ReadBusy[i]                        = 1'b0;
        end
`endif
      end
    end
  end

  // Pending count output is the registered counter.
  always_comb begin
    PendingCount = cnt_q;
  end

endmodule
